// File: rtl/kpn_pkg.sv
// ---------------------------------------------------------------------------
// kpn_pkg
// Shared definitions for the KPN process/channel modules:
//   - kpn_state_e : channel FSM state (precharge of initial tokens, then live)
//   - KPN_*       : default token width / channel depth / initial-token count
//   - kpn_depth() : number of slots for a given address width
// ---------------------------------------------------------------------------
package kpn_pkg;

    typedef enum logic [0:0] {
        KPN_ST_PRECHARGE = 1'b0,
        KPN_ST_RUN       = 1'b1
    } kpn_state_e;

    localparam int KPN_BITS_NUMBER    = 16;
    localparam int KPN_FIFO_ELEMENTS  = 5;
    localparam int KPN_PRECHARGE_DATA = 4;

    function automatic int kpn_depth(input int elements);
        return 1 << elements;
    endfunction

endpackage : kpn_pkg

// File: rtl/kpn_fifo_mem.sv
// ---------------------------------------------------------------------------
// kpn_fifo_mem
// Simple dual-port token store for a KPN channel: one synchronous write port,
// one synchronous read port with a registered output. Written so that the
// array maps onto a block RAM with its output register.
//
// Ports:
//   clk        in   clock, rising edge
//   rd_rst_i   in   synchronous clear of the read output register only
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write slot
//   wr_data_i  in   write token
//   rd_en_i    in   read strobe; rd_data_o updates on the next edge
//   rd_addr_i  in   read slot
//   rd_data_o  out  registered read token (holds when rd_en_i is low)
// ---------------------------------------------------------------------------
module kpn_fifo_mem
    import kpn_pkg::*;
#(
    parameter int BITS_NUMBER   = KPN_BITS_NUMBER,
    parameter int FIFO_ELEMENTS = KPN_FIFO_ELEMENTS
) (
    input  logic                     clk,
    input  logic                     rd_rst_i,
    input  logic                     wr_en_i,
    input  logic [FIFO_ELEMENTS-1:0] wr_addr_i,
    input  logic [BITS_NUMBER-1:0]   wr_data_i,
    input  logic                     rd_en_i,
    input  logic [FIFO_ELEMENTS-1:0] rd_addr_i,
    output logic [BITS_NUMBER-1:0]   rd_data_o
);

    localparam int DEPTH = kpn_depth(FIFO_ELEMENTS);

    logic [BITS_NUMBER-1:0] mem_q [DEPTH];
    logic [BITS_NUMBER-1:0] rd_data_q;

    // NOTE: the array has no reset on purpose; clearing it would force the
    // storage into flops. Only the pointers decide what is valid.
    // NOTE: clocked state is always assigned with <= so every reader in the
    // same edge sees the pre-edge value (this is also what gives
    // read-before-write when both ports hit the same slot).
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : kpn_fifo_mem

// File: rtl/kpn_fifo_channel.sv
// ---------------------------------------------------------------------------
// kpn_fifo_channel
// One KPN channel: a synchronous FIFO between a producer and a consumer that,
// after every reset, first fills itself with NUMBER_OF_PRECHARGE_DATA initial
// tokens (BASE, BASE+STEP, ...) and only then goes live. Occupancy, blocking
// flags and sticky error flags are exported for the network monitor.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high; flushes the channel and
//                   restarts the precharge
//   wr_en      in   producer write request
//   wr_data    in   token to write
//   full       out  writes blocked (forced high during precharge)
//   rd_en      in   consumer read request
//   rd_data    out  registered read token
//   rd_valid   out  rd_data holds a token popped on the previous edge
//   empty      out  reads blocked (forced high during precharge)
//   count      out  stored token count, 0..depth
//   init_done  out  precharge complete, channel live
//   overflow   out  sticky: write attempted while full
//   underflow  out  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module kpn_fifo_channel
    import kpn_pkg::*;
#(
    parameter int                     BITS_NUMBER              = KPN_BITS_NUMBER,
    parameter int                     FIFO_ELEMENTS            = KPN_FIFO_ELEMENTS,
    parameter int                     NUMBER_OF_PRECHARGE_DATA = KPN_PRECHARGE_DATA,
    parameter logic [BITS_NUMBER-1:0] PRECHARGE_BASE           = BITS_NUMBER'(16'h0001),
    parameter logic [BITS_NUMBER-1:0] PRECHARGE_STEP           = BITS_NUMBER'(16'h0001)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [BITS_NUMBER-1:0]   wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [BITS_NUMBER-1:0]   rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic [FIFO_ELEMENTS:0]   count,
    output logic                     init_done,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = kpn_depth(FIFO_ELEMENTS);
    localparam int CW    = FIFO_ELEMENTS + 1;

    localparam logic [CW-1:0]            DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]            PRE_N   = CW'(NUMBER_OF_PRECHARGE_DATA);
    localparam logic [CW-1:0]            CNT_ONE = CW'(1);
    localparam logic [FIFO_ELEMENTS-1:0] PTR_ONE = FIFO_ELEMENTS'(1);

    // With no initial tokens there is nothing to precharge: go live directly.
    localparam kpn_state_e RESET_STATE =
        (NUMBER_OF_PRECHARGE_DATA == 0) ? KPN_ST_RUN : KPN_ST_PRECHARGE;

    generate
        if (NUMBER_OF_PRECHARGE_DATA < 0 || NUMBER_OF_PRECHARGE_DATA > DEPTH) begin : g_bad_precharge
            $error("kpn_fifo_channel: NUMBER_OF_PRECHARGE_DATA must be in 0..2**FIFO_ELEMENTS");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    kpn_state_e               state_q,     state_d;
    logic [FIFO_ELEMENTS-1:0] w_ptr_q,     w_ptr_d;
    logic [FIFO_ELEMENTS-1:0] r_ptr_q,     r_ptr_d;
    logic [CW-1:0]            count_q,     count_d;
    logic [BITS_NUMBER-1:0]   pre_val_q,   pre_val_d;
    logic                     rd_valid_q,  rd_valid_d;
    logic                     overflow_q,  overflow_d;
    logic                     underflow_q, underflow_d;
    logic                     init_done_q, init_done_d;

    logic                     full_c;
    logic                     empty_c;
    logic                     rd_acc;
    logic                     wr_acc;
    logic                     mem_we;
    logic                     mem_re;
    logic [BITS_NUMBER-1:0]   mem_wdata;

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        pre_val_d   = pre_val_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        init_done_d = init_done_q;
        full_c      = 1'b1;
        empty_c     = 1'b1;
        rd_acc      = 1'b0;
        wr_acc      = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_wdata   = wr_data;

        case (state_q)
            KPN_ST_RUN: begin
                full_c  = (count_q == DEPTH_C);
                empty_c = (count_q == '0);
                rd_acc  = rd_en && !empty_c;
                // A read in the same cycle frees the head slot, so a full
                // channel can still take a write.
                wr_acc  = wr_en && (!full_c || rd_acc);

                mem_we     = wr_acc;
                mem_re     = rd_acc;
                rd_valid_d = rd_acc;

                if (wr_acc) begin
                    w_ptr_d = w_ptr_q + PTR_ONE;
                end
                if (rd_acc) begin
                    r_ptr_d = r_ptr_q + PTR_ONE;
                end

                if (wr_acc && !rd_acc) begin
                    count_d = count_q + CNT_ONE;
                end else if (rd_acc && !wr_acc) begin
                    count_d = count_q - CNT_ONE;
                end

                if (wr_en && full_c && !rd_acc) begin
                    overflow_d = 1'b1;
                end
                if (rd_en && empty_c) begin
                    underflow_d = 1'b1;
                end

                init_done_d = 1'b1;
            end

            default: begin
                // Precharge (and recovery from any stray encoding): the port
                // flags stay forced so external requests are ignored and
                // cannot raise the error flags.
                if (count_q < PRE_N) begin
                    mem_we    = 1'b1;
                    mem_wdata = pre_val_q;
                    w_ptr_d   = w_ptr_q + PTR_ONE;
                    count_d   = count_q + CNT_ONE;
                    pre_val_d = pre_val_q + PRECHARGE_STEP;
                end
                if ((PRE_N == '0) || (count_q >= PRE_N - CNT_ONE)) begin
                    state_d     = KPN_ST_RUN;
                    init_done_d = 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            pre_val_q   <= PRECHARGE_BASE;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            pre_val_q   <= pre_val_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            init_done_q <= init_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Token store
    // ------------------------------------------------------------------
    kpn_fifo_mem #(
        .BITS_NUMBER   (BITS_NUMBER),
        .FIFO_ELEMENTS (FIFO_ELEMENTS)
    ) u_mem (
        .clk       (clk),
        .rd_rst_i  (reset),
        .wr_en_i   (mem_we && !reset),
        .wr_addr_i (w_ptr_q),
        .wr_data_i (mem_wdata),
        .rd_en_i   (mem_re),
        .rd_addr_i (r_ptr_q),
        .rd_data_o (rd_data)
    );

    assign full      = full_c;
    assign empty     = empty_c;
    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign init_done = init_done_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : kpn_fifo_channel

// File: tb/tb_kpn_fifo_channel.sv
// ---------------------------------------------------------------------------
// tb_kpn_fifo_channel
// Self-checking bench for kpn_fifo_channel (width 16, depth 8, 4 initial
// tokens 0001..0004). A queue model of the channel predicts every accepted
// read; the predicted token is pushed to a scoreboard when the request is
// driven and popped when rd_valid shows up. A vector table covers the full
// read+write and empty read+write corner cases with hand-derived values.
// ---------------------------------------------------------------------------
module tb_kpn_fifo_channel;

    localparam int BN    = 16;
    localparam int FE    = 3;
    localparam int DEPTH = 8;
    localparam int NPRE  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [BN-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [BN-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [FE:0]   count;
    logic          init_done;
    logic          overflow;
    logic          underflow;

    kpn_fifo_channel #(
        .BITS_NUMBER              (BN),
        .FIFO_ELEMENTS            (FE),
        .NUMBER_OF_PRECHARGE_DATA (NPRE),
        .PRECHARGE_BASE           (16'h0001),
        .PRECHARGE_STEP           (16'h0001)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .count     (count),
        .init_done (init_done),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [BN-1:0] model_q [$];
    logic [BN-1:0] sb_q    [$];
    logic          m_ovf;
    logic          m_unf;
    logic [BN-1:0] m_last;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [BN-1:0] data;
        int            exp_count;
        logic          exp_full;
        logic          exp_empty;
        logic          exp_ovf;
        logic          exp_unf;
        logic          exp_valid;
        logic [BN-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of traffic: predict with the model, drive, then compare.
    task automatic step(input logic w, input logic r, input logic [BN-1:0] d);
        logic full_m, empty_m, rd_acc, wr_acc;
        full_m  = (model_q.size() == DEPTH);
        empty_m = (model_q.size() == 0);
        rd_acc  = r && !empty_m;
        wr_acc  = w && (!full_m || rd_acc);
        if (w && full_m && !rd_acc) m_ovf = 1'b1;
        if (r && empty_m)           m_unf = 1'b1;
        if (rd_acc) sb_q.push_back(model_q.pop_front());
        if (wr_acc) model_q.push_back(d);

        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;

        check("rd_valid", 32'(rd_valid), 32'(rd_acc));
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_read: got token %0h, expected none", rd_data);
            end else begin
                m_last = sb_q.pop_front();
            end
        end
        check("rd_data", 32'(rd_data), 32'(m_last));
        check("count", 32'(count), 32'(model_q.size()));
        check("full", 32'(full), 32'(model_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // Hold reset for 'hold' edges, check the reset state, then wait (bounded)
    // for the precharge to finish. With 'poke' set the ports are hammered
    // during precharge; they must be ignored.
    task automatic reset_and_precharge(input int hold, input logic poke);
        int cycles;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'(0));
        check("rst_init_done", 32'(init_done), 32'(0));
        check("rst_rd_valid", 32'(rd_valid), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_underflow", 32'(underflow), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        check("rst_full", 32'(full), 32'(1));
        check("rst_empty", 32'(empty), 32'(1));

        model_q.delete();
        sb_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_last = '0;

        reset   = 1'b0;
        wr_en   = poke;
        rd_en   = poke;
        wr_data = 16'hDEAD;
        cycles  = 0;
        while (init_done !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (init_done !== 1'b1) begin
                check("pre_full", 32'(full), 32'(1));
                check("pre_empty", 32'(empty), 32'(1));
                check("pre_count", 32'(count), 32'(cycles));
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("precharge_latency", 32'(cycles), 32'(NPRE));

        for (int i = 0; i < NPRE; i++) model_q.push_back(16'(1 + i));
        check("pre_done_count", 32'(count), 32'(NPRE));
        check("pre_done_overflow", 32'(overflow), 32'(0));
        check("pre_done_underflow", 32'(underflow), 32'(0));
        check("pre_done_full", 32'(full), 32'(0));
        check("pre_done_empty", 32'(empty), 32'(0));
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_last  = '0;

        // Starts full (0001..0004, A000..A003); full read+write, drain,
        // then empty read+write and the follow-up read.
        vecs[0]  = '{1'b1, 1'b1, 16'hBEEF, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[1]  = '{1'b0, 1'b1, 16'h0000, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002};
        vecs[2]  = '{1'b0, 1'b1, 16'h0000, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003};
        vecs[3]  = '{1'b0, 1'b1, 16'h0000, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA001};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA002};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA003};
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF};
        vecs[10] = '{1'b1, 1'b1, 16'h1234, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF};
        vecs[11] = '{1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234};

        // Precharge then drain the initial tokens.
        reset_and_precharge(2, 1'b0);
        for (int i = 0; i < NPRE; i++) begin
            step(1'b0, 1'b1, '0);
            step(1'b0, 1'b0, '0);
        end

        // Fill to full, overflow attempt, drain in order.
        reset_and_precharge(1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'hA000 + 16'(i));
        step(1'b1, 1'b0, 16'hA004);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Full and empty simultaneous read+write corners.
        reset_and_precharge(1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'hA000 + 16'(i));
        for (int v = 0; v < 13; v++) begin
            step(vecs[v].wr, vecs[v].rd, vecs[v].data);
            check($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].exp_count));
            check($sformatf("vec%0d_full", v), 32'(full), 32'(vecs[v].exp_full));
            check($sformatf("vec%0d_empty", v), 32'(empty), 32'(vecs[v].exp_empty));
            check($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            check($sformatf("vec%0d_unf", v), 32'(underflow), 32'(vecs[v].exp_unf));
            check($sformatf("vec%0d_valid", v), 32'(rd_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_rdata", v), 32'(rd_data), 32'(vecs[v].exp_rdata));
        end

        // Mid-stream reset with 5 tokens stored and underflow set.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h5000 + 16'(i));
        reset_and_precharge(1, 1'b1);
        for (int i = 0; i < NPRE; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Streaming read+write pairs across the pointer wrap.
        reset_and_precharge(1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'(i));
        for (int i = 0; i < NPRE; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_kpn_fifo_channel

// File: doc/kpn_fifo_channel.md
Name: kpn_fifo_channel

Overview:
- Parametrised synchronous FIFO implementing one KPN channel between a producer and a consumer process.
- Generalises the fixed read-only precharged queue in three ways:
  - full read/write interface;
  - parametrised width and depth;
  - FSM-driven initial-token precharge after reset, with no file load.
- Adds occupancy count, blocking flags and sticky error flags for the network monitor.

Parameters:
- BITS_NUMBER, 16: token width in bits.
- FIFO_ELEMENTS, 5: address bits; depth = 2**FIFO_ELEMENTS.
- NUMBER_OF_PRECHARGE_DATA, 4: initial tokens inserted after reset. Legal range 0..2**FIFO_ELEMENTS; elaboration error otherwise.
- PRECHARGE_BASE, 16'h0001: value of the first initial token.
- PRECHARGE_STEP, 16'h0001: increment between consecutive initial tokens (modulo 2**BITS_NUMBER).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- wr_en  input  1  producer write request.
- wr_data  input  BITS_NUMBER  token to write.
- full  output  1  high: writes are blocked.
- rd_en  input  1  consumer read request.
- rd_data  output  BITS_NUMBER  registered read token.
- rd_valid  output  1  rd_data holds a token popped on the previous edge.
- empty  output  1  high: reads are blocked.
- count  output  FIFO_ELEMENTS+1  stored token count, 0..depth.
- init_done  output  1  precharge complete; channel is live.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset, sampled at the clock edge:
  - pointers = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0, init_done = 0.
  - FSM enters PRECHARGE, or RUN if NUMBER_OF_PRECHARGE_DATA = 0. In the RUN case init_done = 1 on the first edge after reset deasserts.
  - Reset asserted mid-operation discards all contents and restarts precharge.
  - Memory contents are not cleared.
- PRECHARGE state:
  - Writes mem[w_ptr] = PRECHARGE_BASE + i*PRECHARGE_STEP for i = 0..N-1, one token per cycle; w_ptr and count advance.
  - full = 1 and empty = 1 are forced, so external wr_en/rd_en are ignored. They do not set the error flags.
  - After the N-th write the FSM goes to RUN and init_done = 1 from the next cycle.
  - Precharge latency: N cycles after reset deasserts.
- RUN state:
  - full = (count == depth); empty = (count == 0).
  - Write accepted when wr_en && (!full || rd_accepted): mem[w_ptr] <= wr_data, w_ptr++.
  - Read accepted when rd_en && !empty: rd_data <= mem[r_ptr], r_ptr++, rd_valid = 1 on the next cycle. Read latency is 1 cycle.
  - Otherwise rd_valid = 0 and rd_data holds its last value.
  - count: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous events:
  - Full with read+write: both accepted, count stays at depth. Write data goes to the slot freed this cycle; the read returns the old head.
  - Empty with read+write: read rejected (underflow set), write accepted, count = 1. No read-through bypass.
- Pointers are FIFO_ELEMENTS bits and wrap naturally modulo depth.
- Error flags:
  - overflow set on wr_en && full && !rd_accepted in RUN.
  - underflow set on rd_en && empty in RUN.
  - Both cleared only by reset.
- FSM states: PRECHARGE, RUN. No other states; unreachable encodings return to PRECHARGE.

Decomposition:
- Shared package kpn_pkg holds:
  - FSM state typedef (KPN_ST_PRECHARGE, KPN_ST_RUN);
  - default width/depth constants reused by the other KPN process modules.
- One sub-module: kpn_fifo_mem.
  - Simple dual-port RAM: synchronous write, synchronous read, parametrised by BITS_NUMBER and FIFO_ELEMENTS.
  - Keeps storage inferable as block RAM.
- Control, FSM and flags stay in kpn_fifo_channel.

Test Plan (BITS_NUMBER=16, FIFO_ELEMENTS=3 so depth 8, N=4, base 1, step 1):
1. Reset 2 cycles then release -> init_done rises after 4 cycles, count = 4. Four rd_en pulses return 0001, 0002, 0003, 0004 with rd_valid one cycle after each; then empty = 1, count = 0.
2. After precharge, write 4 tokens A000..A003 -> full = 1, count = 8. A fifth write with no read -> overflow = 1, count stays 8, the token is not stored. Drain returns 0001..0004 then A000..A003 in order.
3. Full FIFO, rd_en and wr_en together with wr_data = BEEF -> count stays 8, no overflow, returned head = 0001. BEEF is read eighth.
4. Empty FIFO, rd_en and wr_en together with wr_data = 1234 -> underflow = 1, rd_valid = 0 next cycle, count = 1. The next read returns 1234.
5. Streaming 20 write+read pairs with data 0..19 -> pointer wrap exercised, output sequence matches, count constant, no flags.
6. Assert reset mid-stream with count = 5 -> next cycle count = 0, init_done = 0, flags cleared, rd_valid = 0. Precharge repeats and 0001..0004 are read back.
